// File: rtl/leaky_accu_array.sv
// Multi-channel leaky accumulator bank with saturating event adds,
// prescaled floor-limited decay, threshold flags and a registered max stage.
module leaky_accu_array #(
    parameter int P_CH        = 4,
    parameter int P_W         = 8,
    parameter int P_INC_W     = 6,
    parameter int P_DECAY_DIV = 1,
    localparam int P_IDX_W    = (P_CH > 1) ? $clog2(P_CH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear_all,
    input  logic [P_CH-1:0]       i_event,
    input  logic [P_INC_W-1:0]    i_inc,
    input  logic [P_W-1:0]        i_decay_step,
    input  logic [P_W-1:0]        i_thresh,
    output logic [P_CH*P_W-1:0]   o_ln,
    output logic [P_CH-1:0]       o_clr,
    output logic [P_CH-1:0]       o_fire,
    output logic [P_IDX_W-1:0]    o_max_idx,
    output logic [P_W-1:0]        o_max_val,
    output logic                  o_max_valid
);

    localparam int DIV_W = (P_DECAY_DIV > 1) ? $clog2(P_DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_DECAY_DIV - 1);

    logic [DIV_W-1:0]   r_div;
    logic               tick;
    logic [P_W-1:0]     r_acc   [P_CH];
    logic [P_W-1:0]     acc_nxt [P_CH];
    logic [P_W:0]       sum     [P_CH];
    logic [P_W:0]       inc_ext;
    logic [P_W-1:0]     best_val;
    logic [P_IDX_W-1:0] best_idx;

    assign tick    = (r_div == DIV_LAST);
    assign inc_ext = {{(P_W + 1 - P_INC_W){1'b0}}, i_inc};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Clear beats event beats decay; the extra sum bit catches overflow.
    always_comb begin
        for (int c = 0; c < P_CH; c++) begin
            sum[c]     = {1'b0, r_acc[c]} + inc_ext;
            acc_nxt[c] = r_acc[c];
            if (i_clear_all) begin
                acc_nxt[c] = '0;
            end else if (i_event[c]) begin
                acc_nxt[c] = sum[c][P_W] ? '1 : sum[c][P_W-1:0];
            end else if (tick && (r_acc[c] != '0)) begin
                acc_nxt[c] = (r_acc[c] > i_decay_step) ?
                             (r_acc[c] - i_decay_step) : '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < P_CH; c++) begin
                r_acc[c] <= '0;
            end
            o_clr <= '0;
        end else begin
            for (int c = 0; c < P_CH; c++) begin
                r_acc[c] <= acc_nxt[c];
            end
            o_clr <= i_event & ~{P_CH{i_clear_all}};
        end
    end

    for (genvar g = 0; g < P_CH; g++) begin : g_ch
        assign o_ln[g*P_W +: P_W] = r_acc[g];
        assign o_fire[g] = (i_thresh != '0) && (r_acc[g] >= i_thresh);
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_val = r_acc[0];
        best_idx = '0;
        for (int c = 1; c < P_CH; c++) begin
            if (r_acc[c] > best_val) begin
                best_val = r_acc[c];
                best_idx = P_IDX_W'(c);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_max_idx <= '0;
            o_max_val <= '0;
        end else begin
            o_max_idx <= best_idx;
            o_max_val <= best_val;
        end
    end

    assign o_max_valid = (o_max_val != '0);

endmodule

// File: tb/tb_leaky_accu_array.sv
// Bench for leaky_accu_array: default instance plus a prescaled (div 4)
// instance, both checked every cycle against a queued behavioural model.
module tb_leaky_accu_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       clear_all = 1'b0;
    logic [3:0] ev = '0;
    logic [5:0] inc = '0;
    logic [7:0] step = '0;
    logic [7:0] thresh = '0;

    logic [31:0] ln_a, ln_b;
    logic [3:0]  clr_a, clr_b, fire_a, fire_b;
    logic [1:0]  idx_a, idx_b;
    logic [7:0]  mv_a, mv_b;
    logic        vld_a, vld_b;

    leaky_accu_array dut_a (
        .i_clk(clk), .i_rst(rst), .i_clear_all(clear_all),
        .i_event(ev), .i_inc(inc), .i_decay_step(step),
        .i_thresh(thresh), .o_ln(ln_a), .o_clr(clr_a),
        .o_fire(fire_a), .o_max_idx(idx_a), .o_max_val(mv_a),
        .o_max_valid(vld_a)
    );

    leaky_accu_array #(.P_DECAY_DIV(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clear_all(clear_all),
        .i_event(ev), .i_inc(inc), .i_decay_step(step),
        .i_thresh(thresh), .o_ln(ln_b), .o_clr(clr_b),
        .o_fire(fire_b), .o_max_idx(idx_b), .o_max_val(mv_b),
        .o_max_valid(vld_b)
    );

    typedef struct packed {
        logic [31:0] ln;
        logic [3:0]  clr;
        logic [3:0]  fire;
        logic [1:0]  idx;
        logic [7:0]  mval;
        logic        vld;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int m_acc [2][4];
    int m_clr [2][4];
    int m_div [2];
    int m_idx [2];
    int m_mval[2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k, input int div, output exp_t e);
        int bi, bv, s;
        bit tk;
        if (rst) begin
            m_div[k] = 0; m_idx[k] = 0; m_mval[k] = 0;
            for (int c = 0; c < 4; c++) begin
                m_acc[k][c] = 0; m_clr[k][c] = 0;
            end
        end else begin
            bi = 0; bv = m_acc[k][0];
            for (int c = 1; c < 4; c++)
                if (m_acc[k][c] > bv) begin bv = m_acc[k][c]; bi = c; end
            m_idx[k] = bi; m_mval[k] = bv;
            tk = (m_div[k] == div - 1);
            m_div[k] = tk ? 0 : m_div[k] + 1;
            for (int c = 0; c < 4; c++) begin
                m_clr[k][c] = 0;
                if (clear_all) begin
                    m_acc[k][c] = 0;
                end else if (ev[c]) begin
                    s = m_acc[k][c] + int'(inc);
                    m_acc[k][c] = (s > 255) ? 255 : s;
                    m_clr[k][c] = 1;
                end else if (tk && m_acc[k][c] > 0) begin
                    m_acc[k][c] = (m_acc[k][c] > int'(step)) ?
                                  m_acc[k][c] - int'(step) : 0;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            e.ln[c*8 +: 8] = 8'(m_acc[k][c]);
            e.clr[c]  = (m_clr[k][c] != 0);
            e.fire[c] = (thresh != 0) && (m_acc[k][c] >= int'(thresh));
        end
        e.idx  = 2'(m_idx[k]);
        e.mval = 8'(m_mval[k]);
        e.vld  = (m_mval[k] != 0);
    endtask

    task automatic cyc(input logic r, input logic cl, input logic [3:0] e);
        exp_t xa, xb;
        @(negedge clk);
        rst = r; clear_all = cl; ev = e;
        model_step(0, 1, xa); q_a.push_back(xa);
        model_step(1, 4, xb); q_b.push_back(xb);
        @(posedge clk);
        #1;
        xa = q_a.pop_front();
        xb = q_b.pop_front();
        chk("a_ln", ln_a, xa.ln);     chk("b_ln", ln_b, xb.ln);
        chk("a_clr", clr_a, xa.clr);  chk("b_clr", clr_b, xb.clr);
        chk("a_fire", fire_a, xa.fire); chk("b_fire", fire_b, xb.fire);
        chk("a_idx", idx_a, xa.idx);  chk("b_idx", idx_b, xb.idx);
        chk("a_mval", mv_a, xa.mval); chk("b_mval", mv_b, xb.mval);
        chk("a_vld", vld_a, xa.vld);  chk("b_vld", vld_b, xb.vld);
    endtask

    initial begin
        logic [7:0] sat [5];
        logic [7:0] seq [4];
        logic [7:0] v, prev;
        int nchg, last;
        sat = '{8'd63, 8'd126, 8'd189, 8'd252, 8'd255};
        seq = '{8'd7, 8'd4, 8'd1, 8'd0};

        cyc(1, 0, 4'b0000);
        cyc(1, 0, 4'b0000);
        chk("rst_ln", ln_a, 0);
        chk("rst_vld", vld_a, 0);
        chk("rst_idx", idx_a, 0);

        // single event then linear decay to 0
        step = 1; inc = 63;
        cyc(0, 0, 4'b0001);
        chk("dec_ln1", ln_a[7:0], 63);
        chk("dec_clr1", clr_a[0], 1);
        for (int n = 2; n <= 66; n++) begin
            cyc(0, 0, 4'b0000);
            chk("dec_ln", ln_a[7:0], (n <= 64) ? 64 - n : 0);
            chk("dec_clr", clr_a[0], 0);
        end

        // saturation
        cyc(0, 1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 4'b0010);
            chk("sat", ln_a[15:8], sat[i]);
        end
        cyc(0, 0, 4'b0000);
        chk("sat_dec", ln_a[15:8], 254);

        // prescaled decay with floor on the div-4 instance
        cyc(0, 1, 4'b0000);
        step = 3; inc = 10;
        cyc(0, 0, 4'b0100);
        chk("pre_load", ln_b[23:16], 10);
        prev = 8'd10; nchg = 0; last = 0;
        for (int i = 1; i <= 24; i++) begin
            cyc(0, 0, 4'b0000);
            v = ln_b[23:16];
            if (v != prev) begin
                if (nchg < 4) begin
                    chk("pre_val", v, seq[nchg]);
                    if (nchg > 0) chk("pre_gap", i - last, 4);
                end else begin
                    chk("pre_extra", v, prev);
                end
                last = i; nchg++;
            end
            prev = v;
        end
        chk("pre_cnt", nchg, 4);
        chk("pre_floor", ln_b[23:16], 0);

        // event coinciding with a tick skips decay
        cyc(0, 1, 4'b0000);
        step = 1; inc = 20;
        cyc(0, 0, 4'b1000);
        chk("evt_20", ln_a[31:24], 20);
        inc = 5;
        cyc(0, 0, 4'b1000);
        chk("evt_25", ln_a[31:24], 25);

        // winner-take-all with tie between ch1 and ch3
        cyc(0, 1, 4'b0000);
        step = 0; inc = 50;
        cyc(0, 0, 4'b1011);
        cyc(0, 0, 4'b1010);
        chk("wta_ln1", ln_a[15:8], 100);
        chk("wta_ln3", ln_a[31:24], 100);
        chk("wta_ln0", ln_a[7:0], 50);
        chk("wta_lag", mv_a, 50);
        cyc(0, 0, 4'b0000);
        chk("wta_idx", idx_a, 1);
        chk("wta_val", mv_a, 100);
        chk("wta_vld", vld_a, 1);
        step = 1;
        for (int i = 0; i < 102; i++) cyc(0, 0, 4'b0000);
        chk("wta_end_vld", vld_a, 0);
        chk("wta_end_idx", idx_a, 0);

        // clear overrides simultaneous events
        inc = 30;
        cyc(0, 0, 4'b1111);
        cyc(0, 1, 4'b1111);
        chk("clr_ln", ln_a, 0);
        chk("clr_pulse", clr_a, 0);
        chk("clr_vld_lag", vld_a, 1);
        cyc(0, 0, 4'b0000);
        chk("clr_vld", vld_a, 0);

        // reset mid-decay overrides events
        inc = 40;
        cyc(0, 0, 4'b1111);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0000);
        cyc(1, 0, 4'b1111);
        chk("mrst_ln", ln_a, 0);
        chk("mrst_clr", clr_a, 0);
        chk("mrst_mval", mv_a, 0);
        chk("mrst_ln_b", ln_b, 0);

        // threshold crossing and zero threshold
        thresh = 40; step = 0; inc = 20;
        cyc(0, 0, 4'b0001);
        chk("thr_below", fire_a[0], 0);
        cyc(0, 0, 4'b0001);
        chk("thr_ln", ln_a[7:0], 40);
        chk("thr_fire", fire_a[0], 1);
        thresh = 0; inc = 63;
        #1;
        chk("thr0_40", fire_a, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 4'b0011);
            chk("thr0", fire_a, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
